// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks the PC, fetches over a req/ack memory port and
// buffers {pc, instr} pairs in a small FIFO whose head is decoded into fields.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  OpCode,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm,
  output logic [25:0] target,
  output logic [31:0] out_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      addr_reg, addr_next;
  logic [31:0]      target_reg, target_next;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [31:0]      pc_mem_reg    [DEPTH];
  logic [31:0]      instr_mem_reg [DEPTH];
  logic [DEPTH-1:0] wr_en;
  logic [31:0]      redirect_addr;
  logic [31:0]      head_instr;
  logic             push, pop, space;

  assign redirect_addr = redirect_pc & 32'hFFFF_FFFC;
  assign out_valid     = (count_reg != '0);
  assign pop           = out_valid && out_ready;
  // A redirect in the same cycle as an ack drops that response.
  assign push          = (state_reg == S_REQ) && imem_ack && !redirect;
  assign count_next    = redirect ? '0 : (count_reg + CNT_W'(push) - CNT_W'(pop));
  assign space         = (count_next < CNT_W'(DEPTH));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    target_next = target_reg;
    case (state_reg)
      S_IDLE: begin
        if (redirect) begin
          addr_next  = redirect_addr;
          state_next = S_REQ;
        end else if (space) begin
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect) begin
          if (imem_ack) begin
            addr_next = redirect_addr;
          end else begin
            // Address must stay stable until the stale response returns.
            target_next = redirect_addr;
            state_next  = S_DISCARD;
          end
        end else if (imem_ack) begin
          addr_next = addr_reg + 32'd4;
          if (!space) begin
            state_next = S_IDLE;
          end
        end
      end
      S_DISCARD: begin
        if (imem_ack) begin
          addr_next  = redirect ? redirect_addr : target_reg;
          state_next = S_REQ;
        end else if (redirect) begin
          target_next = redirect_addr;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      addr_reg   <= RESET_PC;
      target_reg <= RESET_PC;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      target_reg <= target_next;
      count_reg  <= count_next;
      if (redirect) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_reg[i]    <= RESET_PC;
        instr_mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          pc_mem_reg[i]    <= addr_reg;
          instr_mem_reg[i] <= imem_rdata;
        end
      end
    end
  end

  assign imem_req   = (state_reg != S_IDLE);
  assign imem_addr  = addr_reg;
  assign head_instr = instr_mem_reg[rd_ptr_reg];
  assign out_pc     = pc_mem_reg[rd_ptr_reg];
  assign OpCode     = head_instr[31:26];
  assign rs         = head_instr[25:21];
  assign rt         = head_instr[20:16];
  assign rd         = head_instr[15:11];
  assign shamt      = head_instr[10:6];
  assign func       = head_instr[5:0];
  assign imm        = head_instr[15:0];
  assign target     = head_instr[25:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: bench-side memory model plus a scoreboard of
// expected {pc, instr} pairs, compared whenever the consumer accepts a word.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  OpCode, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] out_pc;

  instr_fetch #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .OpCode(OpCode), .func(func), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .imm(imm), .target(target), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] fetched[$];
  int          ncmp = 0;
  int          nerr = 0;
  bit          mem_on = 1'b1;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          cyc = 0;
  int          prev_pop_cyc = 0;
  int          last_pop_cyc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h012A_4020;
    if (a == 32'h0000_0104) return 32'h8C88_0004;
    return (a * 32'h0019_660D) ^ 32'h3C6E_F35F;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    sb.push_back(e);
  endtask

  // One cycle: drive memory response, score any accepted word, advance to next negedge.
  task automatic step();
    exp_t e;
    if (mem_on && imem_req) begin
      if (wait_cnt >= ack_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        fetched.push_back(imem_addr);
        wait_cnt   = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
    if (out_valid && out_ready) begin
      chk("sb_has_entry", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("[%0t] pop pc=%08h instr=%08h op=%0d func=%02h", $time, out_pc, e.instr, OpCode, func);
        chk("out_pc", out_pc, e.pc);
        chk("fields", {OpCode, rs, rt, rd, shamt, func, imm, target},
            {e.instr[31:26], e.instr[25:21], e.instr[20:16], e.instr[15:11],
             e.instr[10:6], e.instr[5:0], e.instr[15:0], e.instr[25:0]});
        prev_pop_cyc = last_pop_cyc;
        last_pop_cyc = cyc;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input string tag);
    int budget = 60;
    while (sb.size() > 0 && budget > 0) begin
      step();
      budget--;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    step();
    redirect    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int held;

    // Reset values
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 32'h100);
    chk("rst_fields", {OpCode, rs, rt, rd, shamt, func, imm, target}, 0);

    // Reset and stream
    rst_n = 1'b1;
    step();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h100);
    expect_word(32'h100);
    expect_word(32'h104);
    out_ready = 1'b1;
    drain("stream_drain");
    chk("stream_consecutive", last_pop_cyc - prev_pop_cyc, 1);
    out_ready = 1'b0;

    // Backpressure
    do_redirect(32'h400);
    fetched.delete();
    for (int i = 0; i < 8; i++) step();
    chk("bp_pushes", fetched.size(), 2);
    if (fetched.size() > 0) chk("bp_first_addr", fetched[0], 32'h400);
    chk("bp_req_low", imem_req, 0);
    chk("bp_valid", out_valid, 1);
    for (int i = 0; i < 4; i++) expect_word(32'h400 + 32'(i * 4));
    out_ready = 1'b1;
    drain("bp_drain");
    out_ready = 1'b0;

    // Redirect while a request waits for its ack
    ack_delay = 3;
    do_redirect(32'h800);
    sb.delete();
    for (int n = 0; n < 40 && !(imem_req && imem_addr == 32'h800 && wait_cnt == 1); n++) step();
    chk("nack_setup_addr", imem_addr, 32'h800);
    do_redirect(32'h2003);
    chk("nack_valid_clear", out_valid, 0);
    held = 0;
    while (imem_addr == 32'h800 && held < 20) begin
      chk("nack_req_held", imem_req, 1);
      step();
      held++;
    end
    chk("nack_hold_cycles", held, 2);
    chk("nack_new_addr", imem_addr, 32'h2000);
    expect_word(32'h2000);
    expect_word(32'h2004);
    out_ready = 1'b1;
    drain("nack_drain");
    out_ready = 1'b0;

    // Redirect with same-cycle ack and pop
    ack_delay = 0;
    do_redirect(32'h3000);
    sb.delete();
    expect_word(32'h3000);
    expect_word(32'h3004);
    out_ready = 1'b1;
    for (int n = 0; n < 30 && sb.size() > 1; n++) step();
    do_redirect(32'h5000);
    chk("ackpop_accepted", sb.size(), 0);
    chk("ackpop_valid_clear", out_valid, 0);
    chk("ackpop_req", imem_req, 1);
    chk("ackpop_addr", imem_addr, 32'h5000);
    expect_word(32'h5000);
    expect_word(32'h5004);
    drain("ackpop_drain");
    out_ready = 1'b0;

    // Wrap-around
    do_redirect(32'hFFFF_FFFC);
    fetched.delete();
    sb.delete();
    expect_word(32'hFFFF_FFFC);
    expect_word(32'h0000_0000);
    out_ready = 1'b1;
    drain("wrap_drain");
    chk("wrap_fetch_count", (fetched.size() >= 2), 1);
    if (fetched.size() >= 2) begin
      chk("wrap_fetch0", fetched[0], 32'hFFFF_FFFC);
      chk("wrap_fetch1", fetched[1], 32'h0000_0000);
    end
    out_ready = 1'b0;

    // Asynchronous reset mid-request, then a late ack
    ack_delay = 5;
    do_redirect(32'h7000);
    sb.delete();
    for (int n = 0; n < 40 && !(imem_req && imem_addr == 32'h7000 && wait_cnt >= 1); n++) step();
    chk("areset_setup_req", imem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_req", imem_req, 0);
    chk("areset_addr", imem_addr, 32'h100);
    chk("areset_valid", out_valid, 0);
    chk("areset_out_pc", out_pc, 32'h100);
    chk("areset_fields", {OpCode, rs, rt, rd, shamt, func, imm, target}, 0);
    mem_on   = 1'b0;
    imem_ack = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
    chk("late_ack_valid", out_valid, 0);
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 32'h100);
    wait_cnt  = 0;
    ack_delay = 0;
    mem_on    = 1'b1;
    expect_word(32'h100);
    expect_word(32'h104);
    out_ready = 1'b1;
    drain("restart_drain");
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
